// File: rtl/dice_pkg.sv
// Shared types and segment constants for the two-digit dice display.
// Segment words are active-low with bit0=a through bit6=g.
package dice_pkg;

  localparam int DIE_W = 3;
  localparam int SEG_W = 7;

  typedef logic [DIE_W-1:0] die_t;
  typedef logic [SEG_W-1:0] seg_t;

  localparam seg_t SEG_1     = 7'b1111001;
  localparam seg_t SEG_2     = 7'b0100100;
  localparam seg_t SEG_3     = 7'b0110000;
  localparam seg_t SEG_4     = 7'b0011001;
  localparam seg_t SEG_5     = 7'b0010010;
  localparam seg_t SEG_6     = 7'b0000010;
  localparam seg_t SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/die_to_seg.sv
// Combinational die value to active-low seven-segment decoder.
// Codes outside 1..6 blank the digit rather than showing garbage.
module die_to_seg
  import dice_pkg::*;
(
  input  die_t die_i,
  output seg_t seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    unique case (die_i)
      3'd1:    seg_o = SEG_1;
      3'd2:    seg_o = SEG_2;
      3'd3:    seg_o = SEG_3;
      3'd4:    seg_o = SEG_4;
      3'd5:    seg_o = SEG_5;
      3'd6:    seg_o = SEG_6;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/dice_display.sv
// Captures a dice pair on clock_en and drives two active-low HEX digits.
// Outputs are decoded straight from the capture registers, with no extra output stage.
module dice_display
  import dice_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             clock_en,
  input  logic [DIE_W-1:0] dice1,
  input  logic [DIE_W-1:0] dice2,
  output logic [SEG_W-1:0] HEX0,
  output logic [SEG_W-1:0] HEX1
);

  die_t d1_q, d1_d;
  die_t d2_q, d2_d;

  always_comb begin
    d1_d = d1_q;
    d2_d = d2_q;
    if (clock_en) begin
      d1_d = dice1;
      d2_d = dice2;
    end
  end

  // Reset clears to code 0, which decodes to a blank digit.
  always_ff @(posedge clock) begin
    if (reset) begin
      d1_q <= '0;
      d2_q <= '0;
    end else begin
      d1_q <= d1_d;
      d2_q <= d2_d;
    end
  end

  die_to_seg u_seg0 (
    .die_i (d1_q),
    .seg_o (HEX0)
  );

  die_to_seg u_seg1 (
    .die_i (d2_q),
    .seg_o (HEX1)
  );

endmodule

// File: tb/tb_dice_display.sv
// Scoreboard bench for dice_display: stimulus pushes expected digits per edge,
// a negedge monitor pops and compares them.
module tb_dice_display;

  logic       clock;
  logic       reset;
  logic       clock_en;
  logic [2:0] dice1;
  logic [2:0] dice2;
  logic [6:0] HEX0;
  logic [6:0] HEX1;

  typedef struct {
    logic [6:0] h0;
    logic [6:0] h1;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] BL = 7'b1111111;

  dice_display dut (
    .clock    (clock),
    .reset    (reset),
    .clock_en (clock_en),
    .dice1    (dice1),
    .dice2    (dice2),
    .HEX0     (HEX0),
    .HEX1     (HEX1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive one edge's inputs and queue what the digits must show after it.
  task automatic step(input logic r, input logic en, input logic [2:0] a,
                      input logic [2:0] b, input logic [6:0] e0,
                      input logic [6:0] e1, input string name);
    exp_t e;
    reset    = r;
    clock_en = en;
    dice1    = a;
    dice2    = b;
    e.h0     = e0;
    e.h1     = e1;
    e.name   = name;
    exp_q.push_back(e);
    @(posedge clock);
    #1;
  endtask

  // Monitor: every falling edge presents one settled output pair.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total_cnt++;
        if (HEX0 === e.h0) pass_cnt++;
        else $display("FAIL %s HEX0: got %b expected %b", e.name, HEX0, e.h0);
        total_cnt++;
        if (HEX1 === e.h1) pass_cnt++;
        else $display("FAIL %s HEX1: got %b expected %b", e.name, HEX1, e.h1);
        $display("chk %-8s d1=%0d d2=%0d HEX0=%b HEX1=%b", e.name, dice1, dice2, HEX0, HEX1);
      end
    end
  end

  initial begin
    reset    = 1'b0;
    clock_en = 1'b0;
    dice1    = 3'd0;
    dice2    = 3'd0;

    step(1'b1, 1'b1, 3'd3, 3'd4, BL, BL, "reset");

    for (int i = 0; i < 8; i++)
      step(1'b0, 1'b0, 3'(i), 3'((i + 1) % 8), BL, BL, "hold");

    step(1'b0, 1'b1, 3'd0, 3'd1, BL, S1, "cap01");
    step(1'b0, 1'b1, 3'd1, 3'd2, S1, S2, "cap12");
    step(1'b0, 1'b1, 3'd2, 3'd3, S2, S3, "cap23");
    step(1'b0, 1'b1, 3'd3, 3'd4, S3, S4, "cap34");
    step(1'b0, 1'b1, 3'd4, 3'd5, S4, S5, "cap45");
    step(1'b0, 1'b1, 3'd5, 3'd6, S5, S6, "cap56");
    step(1'b0, 1'b1, 3'd6, 3'd7, S6, BL, "cap67");
    step(1'b0, 1'b1, 3'd7, 3'd0, BL, BL, "cap70");

    step(1'b0, 1'b1, 3'd5, 3'd1, S5, S1, "cap51");
    step(1'b0, 1'b0, 3'd2, 3'd6, S5, S1, "freeze");
    step(1'b0, 1'b0, 3'd3, 3'd3, S5, S1, "freeze");
    step(1'b0, 1'b0, 3'd6, 3'd2, S5, S1, "freeze");
    step(1'b0, 1'b0, 3'd0, 3'd7, S5, S1, "freeze");
    step(1'b0, 1'b0, 3'd1, 3'd5, S5, S1, "freeze");
    step(1'b0, 1'b0, 3'd4, 3'd4, S5, S1, "freeze");
    step(1'b0, 1'b0, 3'd7, 3'd0, S5, S1, "freeze");
    step(1'b0, 1'b0, 3'd6, 3'd6, S5, S1, "freeze");

    step(1'b1, 1'b1, 3'd6, 3'd2, BL, BL, "rstprio");
    step(1'b0, 1'b1, 3'd6, 3'd2, S6, S2, "cap62");
    step(1'b0, 1'b1, 3'd0, 3'd7, BL, BL, "inval");
    step(1'b0, 1'b0, 3'd4, 3'd3, BL, BL, "invhold");

    for (int k = 0; k < 4; k++) begin
      if (exp_q.size() == 0) break;
      @(negedge clock);
      #1;
    end
    if (exp_q.size() != 0) begin
      total_cnt++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
